btn_press_conditioner: RTL and testbench

- Upstream input stage for the genius game FSM.
- Synchronises and debounces the three player buttons.
- Arbitrates so only one press is accepted at a time, then emits a single-cycle one-hot pulse plus a 2-bit code (0/1/2) that matches the sequence-number encoding.
- The FSM consumes press_valid and press_code instead of raw button levels, so a held button counts as exactly one choice.

---
 rtl/btn_press_conditioner.sv | 143 ++++++++++++++
 tb/tb_btn_press_conditioner.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/btn_press_conditioner.sv
// rtl/btn_press_conditioner.sv - sync, debounce and one-at-a-time arbitration of three player buttons
// Optional multi-press flag built only when MULTI_PRESS_DETECT_EN is defined.
module btn_press_conditioner #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int HOLDOFF_CYCLES  = 50000,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] btn_raw,
  input  logic       enable,
  output logic [2:0] btn_pulse,
  output logic       press_valid,
  output logic [1:0] press_code,
  output logic [2:0] btn_level,
  output logic       busy,
  output logic       multi_press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, HELD, HOLDOFF} state_t;

  logic [2:0]    btn_pol;
  logic [2:0]    sync1_q, s_q;
  logic [2:0]    d_q, d_d;
  logic [CW-1:0] cnt_q [3];
  logic [CW-1:0] cnt_d [3];
  logic [2:0]    rise, fall;
  logic [2:0]    win_oh;
  logic [1:0]    win_code;

  state_t        state_q;
  logic [2:0]    owner_q;
  logic [HW-1:0] hold_q;
  logic [2:0]    pulse_q;
  logic          valid_q;
  logic [1:0]    code_q;
  logic          busy_q;
  logic          multi_q;

  assign btn_pol = BTN_ACTIVE_LOW ? ~btn_raw : btn_raw;

  // A level is adopted only after it has differed for DEBOUNCE_CYCLES consecutive synced cycles.
  always_comb begin
    d_d = d_q;
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = '0;
      if (s_q[i] != d_q[i]) begin
        if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) d_d[i] = ~d_q[i];
        else cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  assign rise     = d_d & ~d_q;
  assign fall     = ~d_d & d_q;
  assign win_oh   = rise & (~rise + 3'd1);
  assign win_code = win_oh[1] ? 2'd1 : (win_oh[2] ? 2'd2 : 2'd0);

  always_ff @(posedge clock) begin
    if (!reset) begin
      sync1_q <= '0;
      s_q     <= '0;
      d_q     <= '0;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= btn_pol;
      s_q     <= sync1_q;
      d_q     <= d_d;
      for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      hold_q  <= '0;
      pulse_q <= '0;
      valid_q <= 1'b0;
      code_q  <= '0;
      busy_q  <= 1'b0;
      multi_q <= 1'b0;
    end else begin
      pulse_q <= '0;
      valid_q <= 1'b0;
      code_q  <= '0;
      multi_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // Any already-held button blocks acceptance; unaccepted rises are dropped.
          if (enable && (rise != 3'b000) && (d_q == 3'b000)) begin
            owner_q <= win_oh;
            pulse_q <= win_oh;
            valid_q <= 1'b1;
            code_q  <= win_code;
            state_q <= HELD;
            busy_q  <= 1'b1;
`ifdef MULTI_PRESS_DETECT_EN
            multi_q <= (rise[0] & rise[1]) | (rise[0] & rise[2]) | (rise[1] & rise[2]);
`endif
          end
        end
        HELD: begin
`ifdef MULTI_PRESS_DETECT_EN
          multi_q <= |(rise & ~owner_q);
`endif
          if (|(fall & owner_q)) begin
            if (HOLDOFF_CYCLES > 0) begin
              hold_q  <= HW'(HOLDOFF_CYCLES > 0 ? HOLDOFF_CYCLES - 1 : 0);
              state_q <= HOLDOFF;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        HOLDOFF: begin
          if (hold_q != '0) begin
            hold_q <= hold_q - HW'(1);
          end else if (d_q == 3'b000) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign btn_pulse   = pulse_q;
  assign press_valid = valid_q;
  assign press_code  = code_q;
  assign btn_level   = d_q;
  assign busy        = busy_q;
  assign multi_press = multi_q;

endmodule

// File: tb/tb_btn_press_conditioner.sv
// tb/tb_btn_press_conditioner.sv - directed bench for btn_press_conditioner (DEBOUNCE=4, HOLDOFF=3, active-high)
module tb_btn_press_conditioner;

  logic       clock = 1'b0;
  logic       reset;
  logic [2:0] btn_raw;
  logic       enable;
  logic [2:0] btn_pulse;
  logic       press_valid;
  logic [1:0] press_code;
  logic [2:0] btn_level;
  logic       busy;
  logic       multi_press;

  int checks = 0;
  int passed = 0;
  int pulses = 0;
  int viol   = 0;
  int snap;
  logic prev_valid = 1'b0;
  logic exp_multi;

  btn_press_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .HOLDOFF_CYCLES (3),
    .BTN_ACTIVE_LOW (1'b0)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .btn_raw    (btn_raw),
    .enable     (enable),
    .btn_pulse  (btn_pulse),
    .press_valid(press_valid),
    .press_code (press_code),
    .btn_level  (btn_level),
    .busy       (busy),
    .multi_press(multi_press)
  );

  always #5 clock = ~clock;

  // Protocol invariants watched over the whole run.
  always @(negedge clock) begin
    if (press_valid) pulses++;
    if (press_valid && prev_valid) viol++;
    if ($countones(btn_pulse) > 1) viol++;
    if (press_valid !== (btn_pulse != 3'b000)) viol++;
    if (!press_valid && press_code != 2'd0) viol++;
    prev_valid = press_valid;
  end

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_press(input string tag, input logic [2:0] pulse, input logic [1:0] code);
    check({tag, "_pulse"}, 32'(btn_pulse), 32'(pulse));
    check({tag, "_valid"}, 32'(press_valid), 32'(pulse != 3'b000));
    check({tag, "_code"}, 32'(press_code), 32'(code));
  endtask

  initial begin
`ifdef MULTI_PRESS_DETECT_EN
    exp_multi = 1'b1;
`else
    exp_multi = 1'b0;
`endif
    reset = 1'b0; btn_raw = 3'b000; enable = 1'b1;
    tick(3);
    check("rst_pulse", 32'(btn_pulse), 0);
    check("rst_level", 32'(btn_level), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_code", 32'(press_code), 0);

    // 1: single press on button 1
    reset = 1'b1; btn_raw = 3'b010;
    tick(5);
    check_press("t1_pre", 3'b000, 2'd0);
    tick(1);
    check_press("t1_edge6", 3'b010, 2'd1);
    check("t1_level_e6", 32'(btn_level), 32'(3'b010));
    tick(1);
    check_press("t1_drop", 3'b000, 2'd0);
    check("t1_busy", 32'(busy), 1);
    tick(12);
    check("t1_level_hold", 32'(btn_level), 32'(3'b010));
    btn_raw = 3'b000;
    tick(8);
    check("t1_busy_holdoff", 32'(busy), 1);
    tick(1);
    check("t1_busy_idle", 32'(busy), 0);
    check("t1_level_rel", 32'(btn_level), 0);

    // 2: bounce shorter than debounce window
    snap = pulses;
    btn_raw = 3'b001; tick(2);
    btn_raw = 3'b000; tick(2);
    btn_raw = 3'b001; tick(2);
    btn_raw = 3'b000; tick(10);
    check("t2_no_pulse", 32'(pulses), 32'(snap));
    check("t2_level", 32'(btn_level), 0);

    // 3: simultaneous press of 0 and 2, lowest index wins
    btn_raw = 3'b101;
    tick(6);
    check_press("t3", 3'b001, 2'd0);
    check("t3_multi", 32'(multi_press), 32'(exp_multi));
    check("t3_level", 32'(btn_level), 32'(3'b101));
    tick(1);
    check("t3_multi_drop", 32'(multi_press), 0);
    btn_raw = 3'b000;
    tick(20);
    check("t3_busy", 32'(busy), 0);

    // 4: press during holdoff is dropped, later repress accepted
    btn_raw = 3'b100;
    tick(6);
    check_press("t4_b2", 3'b100, 2'd2);
    btn_raw = 3'b000;
    tick(2);
    btn_raw = 3'b001;
    snap = pulses;
    tick(10);
    check("t4_dropped", 32'(pulses), 32'(snap));
    check("t4_busy_held", 32'(busy), 1);
    check("t4_level", 32'(btn_level), 32'(3'b001));
    btn_raw = 3'b000;
    tick(10);
    check("t4_busy_free", 32'(busy), 0);
    check("t4_no_pulse", 32'(pulses), 32'(snap));
    btn_raw = 3'b001;
    tick(6);
    check_press("t4_repress", 3'b001, 2'd0);
    btn_raw = 3'b000;
    tick(15);

    // 5: enable gating
    enable = 1'b0; btn_raw = 3'b010;
    snap = pulses;
    tick(6);
    check("t5_no_pulse", 32'(btn_pulse), 0);
    check("t5_level", 32'(btn_level), 32'(3'b010));
    check("t5_busy", 32'(busy), 0);
    enable = 1'b1;
    tick(5);
    check("t5_still_none", 32'(pulses), 32'(snap));
    btn_raw = 3'b000;
    tick(8);
    btn_raw = 3'b010;
    tick(6);
    check_press("t5_repress", 3'b010, 2'd1);
    btn_raw = 3'b000;
    tick(15);

    // 6: reset in HELD with button still held
    btn_raw = 3'b100;
    tick(6);
    check_press("t6_first", 3'b100, 2'd2);
    tick(2);
    reset = 1'b0;
    tick(1);
    check("t6_rst_pulse", 32'(btn_pulse), 0);
    check("t6_rst_level", 32'(btn_level), 0);
    check("t6_rst_busy", 32'(busy), 0);
    check("t6_rst_multi", 32'(multi_press), 0);
    tick(2);
    reset = 1'b1;
    tick(5);
    check_press("t6_pre", 3'b000, 2'd0);
    tick(1);
    check_press("t6_edge6", 3'b100, 2'd2);
    check("t6_busy", 32'(busy), 1);
    btn_raw = 3'b000;
    tick(15);

    check("invariants", 32'(viol), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
